// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: controller states and
// the default operand width.
package serial_arith_pkg;

   localparam int SUB_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: computes x - y - bin, giving the difference bit
// and the borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic x_eq_y;

   assign x_eq_y = ~(x ^ y);
   assign d      = x ^ y ^ bin;
   // Borrow when y exceeds x outright, or when they tie and a borrow is pending.
   assign bout   = (~x & y) | (x_eq_y & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one full-subtractor cell
// reused every cycle with a registered borrow between bits.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   sub_state_t       state;
   sub_state_t       state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] diff_sh;
   logic [WIDTH-1:0] diff_sh_nxt;
   logic             borrow;
   logic [CW-1:0]    cnt;

   logic             load;
   logic             step;
   logic             last;
   logic             cell_d;
   logic             cell_b;

   full_subtractor u_cell (
      .x    (a_sh[0]),
      .y    (b_sh[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_b)
   );

   // New difference bits enter at the MSB so the LSB-first stream lands in place.
   assign diff_sh_nxt = {cell_d, diff_sh[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
               load      = 1'b1;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_nxt = SHIFT;
               load      = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         borrow  <= 1'b0;
         cnt     <= '0;
      end else if (load) begin
         a_sh    <= a;
         b_sh    <= b;
         diff_sh <= '0;
         borrow  <= 1'b0;
         cnt     <= '0;
      end else if (step) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         diff_sh <= diff_sh_nxt;
         borrow  <= cell_b;
         // Counter parks on its last value rather than wrapping.
         if (!last) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Status flags follow the next state so they are registered yet line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         diff <= '0;
         bout <= 1'b0;
      end else begin
         busy <= (state_nxt == SHIFT);
         done <= (state_nxt == DONE);
         if (last) begin
            diff <= diff_sh_nxt;
            bout <= cell_b;
         end
      end
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of the bit-serial subtractor at WIDTH=8 and
// WIDTH=13, plus an exhaustive check of the one-bit cell.
module tb_serial_subtractor;

   logic        clk;
   logic        rst_n;

   logic        start8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        busy8;
   logic        done8;
   logic [7:0]  diff8;
   logic        bout8;

   logic        start13;
   logic [12:0] a13;
   logic [12:0] b13;
   logic        busy13;
   logic        done13;
   logic [12:0] diff13;
   logic        bout13;

   logic        fx;
   logic        fy;
   logic        fbin;
   logic        fd;
   logic        fbout;

   int          n_cmp;
   int          n_err;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .diff  (diff8),
      .bout  (bout8)
   );

   serial_subtractor #(.WIDTH(13)) u_dut13 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start13),
      .a     (a13),
      .b     (b13),
      .busy  (busy13),
      .done  (done13),
      .diff  (diff13),
      .bout  (bout13)
   );

   full_subtractor u_cell (
      .x    (fx),
      .y    (fy),
      .bin  (fbin),
      .d    (fd),
      .bout (fbout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
      end
   endtask

   task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input string tag);
      int n;
      int nb;
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      n = 0; nb = 0;
      while (!done8 && n < 40) begin
         if (busy8) nb++;
         n++;
         @(negedge clk);
      end
      check({tag, "_done"}, 32'(done8), 32'd1);
      check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
      check({tag, "_overlap"}, 32'(busy8), 32'd0);
      check({tag, "_diff"}, 32'(diff8), 32'(ed));
      check({tag, "_bout"}, 32'(bout8), 32'(eb));
      @(negedge clk);
      check({tag, "_pulse"}, 32'(done8), 32'd0);
   endtask

   task automatic run13(input logic [12:0] av, input logic [12:0] bv,
                        input logic [12:0] ed, input logic eb, input string tag);
      int n;
      int nb;
      @(negedge clk);
      a13 = av; b13 = bv; start13 = 1'b1;
      @(negedge clk);
      start13 = 1'b0; a13 = 13'($urandom); b13 = 13'($urandom);
      n = 0; nb = 0;
      while (!done13 && n < 60) begin
         if (busy13) nb++;
         n++;
         @(negedge clk);
      end
      check({tag, "_done"}, 32'(done13), 32'd1);
      check({tag, "_busy_cycles"}, 32'(nb), 32'd13);
      check({tag, "_diff"}, 32'(diff13), 32'(ed));
      check({tag, "_bout"}, 32'(bout13), 32'(eb));
   endtask

   initial begin
      int n;
      int nd;
      int r;
      logic [7:0]  ra8, rb8;
      logic [12:0] ra13, rb13;

      n_cmp = 0; n_err = 0;
      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start13 = 1'b0; a13 = '0; b13 = '0;
      fx = 1'b0; fy = 1'b0; fbin = 1'b0;

      // Cell truth table from integer arithmetic x - y - bin.
      for (int i = 0; i < 8; i++) begin
         fx = i[2]; fy = i[1]; fbin = i[0];
         #1;
         r = int'(fx) - int'(fy) - int'(fbin);
         check($sformatf("cell_d_%0d", i), 32'(fd), 32'(r & 1));
         check($sformatf("cell_b_%0d", i), 32'(fbout), (r < 0) ? 32'd1 : 32'd0);
      end

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_bout", 32'(bout8), 32'd0);
      check("rst_diff13", 32'(diff13), 32'd0);
      rst_n = 1'b1;

      run8(8'h05, 8'h03, 8'h02, 1'b0, "d5m3");
      run8(8'h03, 8'h05, 8'hFE, 1'b1, "d3m5");
      run8(8'h00, 8'h00, 8'h00, 1'b0, "d0m0");
      run8(8'hFF, 8'h01, 8'hFE, 1'b0, "dFFm1");
      run8(8'h00, 8'hFF, 8'h01, 1'b1, "d0mFF");

      // Start held high: two results spaced WIDTH+1 cycles apart.
      @(negedge clk);
      a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20;
      n = 0;
      while (!done8 && n < 40) begin n++; @(negedge clk); end
      check("b2b1_done", 32'(done8), 32'd1);
      check("b2b1_diff", 32'(diff8), 32'h7F);
      check("b2b1_bout", 32'(bout8), 32'd0);
      @(negedge clk);
      a8 = 8'hC3; b8 = 8'h3C;
      n = 1;
      while (!done8 && n < 40) begin n++; @(negedge clk); end
      start8 = 1'b0;
      check("b2b_spacing", 32'(n), 32'd9);
      check("b2b2_diff", 32'(diff8), 32'hF0);
      check("b2b2_bout", 32'(bout8), 32'd1);
      @(negedge clk);
      check("b2b_end_done", 32'(done8), 32'd0);
      check("b2b_end_busy", 32'(busy8), 32'd0);

      // Start pulse while shifting must not disturb the operation.
      @(negedge clk);
      a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      repeat (2) @(negedge clk);
      a8 = 8'hAA; b8 = 8'h11; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 40) begin n++; @(negedge clk); end
      check("mid_done", 32'(done8), 32'd1);
      check("mid_diff", 32'(diff8), 32'h02);
      check("mid_bout", 32'(bout8), 32'd0);
      nd = 0;
      repeat (12) begin @(negedge clk); if (done8) nd++; end
      check("mid_no_extra", 32'(nd), 32'd0);

      // Reset during the 4th shift cycle aborts the operation.
      run8(8'h10, 8'h20, 8'hF0, 1'b1, "pre_rst");
      @(negedge clk);
      a8 = 8'h5A; b8 = 8'h0F; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy8), 32'd0);
      check("arst_diff", 32'(diff8), 32'd0);
      check("arst_bout", 32'(bout8), 32'd0);
      check("arst_done", 32'(done8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (12) begin @(negedge clk); if (done8 || busy8) nd++; end
      check("arst_no_done", 32'(nd), 32'd0);
      run8(8'h5A, 8'h0F, 8'h4B, 1'b0, "post_rst");

      run13(13'h0005, 13'h0003, 13'h0002, 1'b0, "w13_5m3");
      run13(13'h0000, 13'h0001, 13'h1FFF, 1'b1, "w13_0m1");

      for (int k = 0; k < 1000; k++) begin
         ra8 = 8'($urandom); rb8 = 8'($urandom);
         run8(ra8, rb8, 8'(ra8 - rb8), (ra8 < rb8), "rnd8");
      end
      for (int k = 0; k < 1000; k++) begin
         ra13 = 13'($urandom); rb13 = 13'($urandom);
         run13(ra13, rb13, 13'(ra13 - rb13), (ra13 < rb13), "rnd13");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing a − b one bit per clock, LSB first. It reuses a single 1-bit full-subtractor cell and a registered borrow. It complements the combinational full-adder cell, running the same one-bit datapath in the opposite arithmetic direction. The block is a compact, sequential arithmetic unit driven by a start/done handshake from a controlling FSM or testbench.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled on rising clk edges
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; diff and bout are valid
- diff  output  WIDTH  a − b modulo 2^WIDTH
- bout  output  1  final borrow; 1 when a < b (unsigned)

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: processing one bit per cycle.
  - DONE: presenting the result.
- IDLE, start=1 → SHIFT:
  - Load a and b into shift registers.
  - Clear the borrow register and the bit counter.
  - Leave diff unchanged.
- SHIFT, each edge:
  - Cell inputs x=a_sh[0], y=b_sh[0], bin=borrow.
  - d = x ^ y ^ bin.
  - bnext = (~x & y) | (~(x ^ y) & bin).
  - diff_sh shifts right with d entering at bit WIDTH−1.
  - a_sh and b_sh shift right.
  - borrow ← bnext; counter increments.
- SHIFT, edge on which counter == WIDTH−1 → DONE:
  - diff ← final diff_sh; bout ← bnext.
- DONE → IDLE unconditionally after one cycle, or → SHIFT if start=1 in DONE (back-to-back accepted, new operands loaded).
- start in SHIFT is ignored; a and b are don't-care outside the accepting edge.
- diff and bout hold their last result until the next DONE transition.
- Counter width is $clog2(WIDTH); it never wraps past WIDTH−1.
- Unsigned semantics only; signed overflow is not reported.

## Timing
- Reset values (asserted asynchronously, immediately): state=IDLE, busy=0, done=0, diff=0, bout=0, borrow=0, counter=0, shift registers=0.
- Reset mid-SHIFT aborts the operation. No done pulse is produced and the result is discarded.
- Release of rst_n takes effect at the next rising edge. start is honored on the first edge after release.
- Start accepted at edge E0:
  - busy=1 from after E0 through E(WIDTH). It is a registered output, high exactly WIDTH cycles.
  - done=1 for exactly one cycle, after E(WIDTH) until E(WIDTH+1).
  - diff and bout update at E(WIDTH) and are stable while done=1.
- Latency: WIDTH+1 edges from the accepting edge to the done deassert edge.
- Throughput: one result per WIDTH+1 cycles with start held high continuously.
- busy and done are never high in the same cycle. All outputs are registered, with no combinational path from inputs.

## Structure
- Shared package serial_arith_pkg holds:
  - State enum: IDLE, SHIFT, DONE.
  - Default-width constant.
- Sub-module full_subtractor (combinational ports x, y, bin, d, bout) is the single bit cell. It is instantiated once and also unit-tested alone.
- Top level contains the FSM, counter, three shift registers, borrow flop and output registers.

## Test plan
- full_subtractor exhaustive: all 8 (x, y, bin) combinations → d and bout match the truth table, e.g. x=0, y=1, bin=1 → d=0, bout=1.
- WIDTH=8, a=5, b=3, start pulse → busy high 8 cycles, then done for 1 cycle with diff=0x02, bout=0.
- a=3, b=5 → diff=0xFE, bout=1. a=0x00, b=0x00 → diff=0x00, bout=0. a=0xFF, b=0x01 → diff=0xFE, bout=0.
- start held high; operands 0x80−0x01 then 0x10−0x20 → consecutive results 0x7F/bout=0 and 0xF0/bout=1, 9 cycles apart. A start pulse mid-SHIFT is ignored and the result is unchanged.
- rst_n low for 1 cycle at the 4th SHIFT cycle → outputs go to 0 immediately and no done pulse follows. A new start after release gives the correct result.
- Randomized 1000 operations, WIDTH=8 and WIDTH=13 → diff == (a−b) mod 2^WIDTH and bout == (a<b) on every done.
